// File: rtl/loader_pkg.sv
// Shared ROM-loader definitions: region encodings, the board region table and stream marker bytes.
package loader_pkg;

    typedef enum logic [0:0] {
        ENC_LINEAR = 1'b0,
        ENC_SWAP16 = 1'b1
    } region_encoding_t;

    typedef struct packed {
        logic [31:0]      base_addr;
        region_encoding_t encoding;
        logic             enable;
    } region_desc_t;

    localparam logic [7:0] REGION_NEXT = 8'hFF;
    localparam logic [7:0] REGION_END  = 8'hFE;

    localparam int LOAD_REGIONS_N = 16;
    localparam int LR_W           = $clog2(LOAD_REGIONS_N);

    localparam region_desc_t LOAD_REGIONS [LOAD_REGIONS_N] = '{
        '{32'h0010_0000, ENC_LINEAR, 1'b1}, '{32'h0020_0000, ENC_SWAP16, 1'b1},
        '{32'h0030_0000, ENC_LINEAR, 1'b0}, '{32'h0040_0000, ENC_LINEAR, 1'b1},
        '{32'h0050_0000, ENC_LINEAR, 1'b1}, '{32'h0060_0000, ENC_LINEAR, 1'b1},
        '{32'h0070_0000, ENC_LINEAR, 1'b1}, '{32'h0080_0000, ENC_LINEAR, 1'b1},
        '{32'h0090_0000, ENC_LINEAR, 1'b1}, '{32'h00A0_0000, ENC_LINEAR, 1'b1},
        '{32'h00B0_0000, ENC_LINEAR, 1'b1}, '{32'h00C0_0000, ENC_LINEAR, 1'b1},
        '{32'h00D0_0000, ENC_LINEAR, 1'b1}, '{32'h00E0_0000, ENC_LINEAR, 1'b1},
        '{32'h00F0_0000, ENC_LINEAR, 1'b1}, '{32'h0100_0000, ENC_LINEAR, 1'b1}
    };

    // Indices past the table come back as a disabled region.
    function automatic region_desc_t region_lookup(input logic [7:0] idx);
        region_desc_t d;
        d = '0;
        if (idx < 8'(LOAD_REGIONS_N))
            d = LOAD_REGIONS[idx[LR_W-1:0]];
        return d;
    endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Lane buffer for one memory word: collects bytes with their enables, presents the word
// (optionally 16-bit byte-swapped) including the current byte, and clears once it issues.
module loader_word_packer
    import loader_pkg::*;
#(
    parameter int   DATA_W = 64,
    localparam int  BE_W   = DATA_W / 8,
    localparam int  LB     = $clog2(BE_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              issue,
    input  logic              swap,
    input  logic [LB-1:0]     lane,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word_data,
    output logic [BE_W-1:0]   word_be
);

    logic [DATA_W-1:0] buf_q, buf_d, fill;
    logic [BE_W-1:0]   be_q, be_d, fill_be;

    always_comb begin
        fill                      = buf_q;
        fill_be                   = be_q;
        fill[{lane, 3'b000} +: 8] = byte_in;
        fill_be[lane]             = 1'b1;
        buf_d                     = buf_q;
        be_d                      = be_q;
        if (wr) begin
            if (issue) begin
                buf_d = '0;
                be_d  = '0;
            end else begin
                buf_d = fill;
                be_d  = fill_be;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q <= '0;
            be_q  <= '0;
        end else begin
            buf_q <= buf_d;
            be_q  <= be_d;
        end
    end

    for (genvar p = 0; p < BE_W / 2; p++) begin : g_pair
        assign word_data[p*16 +: 16] = swap ? {fill[p*16 +: 8], fill[p*16+8 +: 8]}
                                            : fill[p*16 +: 16];
        assign word_be[p*2 +: 2]     = swap ? {fill_be[p*2], fill_be[p*2+1]}
                                            : fill_be[p*2 +: 2];
    end

endmodule

// File: rtl/rom_region_packer.sv
// ROM download parser: board config, region headers and payload, packed into DATA_W-bit
// writes over a toggle req/ack port at per-region base addresses.
module rom_region_packer
    import loader_pkg::*;
#(
    parameter int   DATA_W    = 64,
    parameter int   ADDR_W    = 32,
    parameter int   CFG_BYTES = 2,
    parameter int   N_REGIONS = 16,
    localparam int  BE_W      = DATA_W / 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_strobe,
    input  logic [7:0]             in_data,
    output logic                   in_wait,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_data,
    output logic [BE_W-1:0]        mem_be,
    output logic                   mem_req,
    input  logic                   mem_ack,
    output logic [CFG_BYTES*8-1:0] board_cfg,
    output logic                   done,
    output logic                   error,
    output logic [15:0]            checksum
);

    localparam int LB    = $clog2(BE_W);
    localparam int RI_W  = $clog2(N_REGIONS);
    localparam int CFG_W = CFG_BYTES * 8;
    localparam int CC_W  = $clog2(CFG_BYTES + 1);

    localparam logic [2:0] S_CFG    = 3'd0;
    localparam logic [2:0] S_REGION = 3'd1;
    localparam logic [2:0] S_SIZE0  = 3'd2;
    localparam logic [2:0] S_SIZE1  = 3'd3;
    localparam logic [2:0] S_SIZE2  = 3'd4;
    localparam logic [2:0] S_DATA   = 3'd5;
    localparam logic [2:0] S_WAIT   = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [CC_W-1:0]   cfg_cnt_q, cfg_cnt_d;
    logic [CFG_W-1:0]  cfg_sh_q, cfg_sh_d, board_cfg_q, board_cfg_d;
    logic [RI_W-1:0]   region_idx_q, region_idx_d;
    logic              region_bad_q, region_bad_d;
    logic [23:0]       size_q, size_d, offset_q, offset_d;
    logic [31:0]       base_q, base_d;
    logic              swap_q, swap_d, enable_q, enable_d;
    logic [15:0]       checksum_q, checksum_d;
    logic              error_q, error_d, done_q, done_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic              mem_req_q, mem_req_d;

    logic              take, last, byte_wr, issue;
    logic [LB-1:0]     lane;
    logic [DATA_W-1:0] word_data;
    logic [BE_W-1:0]   word_be;
    region_desc_t      desc;

    assign in_wait = (state_q == S_WAIT);
    assign take    = in_strobe && !in_wait;
    assign lane    = offset_q[LB-1:0];
    assign last    = (offset_q == size_q - 24'd1);
    assign desc    = region_lookup(8'(region_idx_q));

    loader_word_packer #(.DATA_W(DATA_W)) u_packer (
        .clk       (clk),
        .reset     (reset),
        .wr        (byte_wr),
        .issue     (issue),
        .swap      (swap_q),
        .lane      (lane),
        .byte_in   (in_data),
        .word_data (word_data),
        .word_be   (word_be)
    );

    always_comb begin
        state_d      = state_q;
        cfg_cnt_d    = cfg_cnt_q;
        cfg_sh_d     = cfg_sh_q;
        board_cfg_d  = board_cfg_q;
        region_idx_d = region_idx_q;
        region_bad_d = region_bad_q;
        size_d       = size_q;
        offset_d     = offset_q;
        base_d       = base_q;
        swap_d       = swap_q;
        enable_d     = enable_q;
        checksum_d   = checksum_q;
        error_d      = error_q;
        done_d       = done_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_be_d     = mem_be_q;
        mem_req_d    = mem_req_q;
        byte_wr      = 1'b0;
        issue        = 1'b0;

        // A byte offered while stalled is lost; flag it so the host can retry the download.
        if (in_strobe && in_wait)
            error_d = 1'b1;

        case (state_q)
            S_CFG: if (take) begin
                cfg_sh_d = CFG_W'({cfg_sh_q, in_data});
                if (cfg_cnt_q == CC_W'(CFG_BYTES - 1)) begin
                    board_cfg_d = cfg_sh_d;
                    cfg_cnt_d   = '0;
                    state_d     = S_REGION;
                end else begin
                    cfg_cnt_d = cfg_cnt_q + 1'b1;
                end
            end
            S_REGION: if (take) begin
                state_d = S_SIZE0;
                if (in_data == REGION_END) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (in_data == REGION_NEXT) begin
                    region_idx_d = (region_idx_q == RI_W'(N_REGIONS - 1)) ? '0
                                                                          : region_idx_q + 1'b1;
                    region_bad_d = 1'b0;
                end else if (32'(in_data) < N_REGIONS) begin
                    region_idx_d = RI_W'(in_data);
                    region_bad_d = 1'b0;
                end else begin
                    // Keep the last good index so a following NEXT still has a reference.
                    region_bad_d = 1'b1;
                    error_d      = 1'b1;
                end
            end
            S_SIZE0: if (take) begin
                size_d  = {size_q[15:0], in_data};
                state_d = S_SIZE1;
            end
            S_SIZE1: if (take) begin
                size_d  = {size_q[15:0], in_data};
                state_d = S_SIZE2;
            end
            S_SIZE2: if (take) begin
                size_d   = {size_q[15:0], in_data};
                base_d   = desc.base_addr;
                swap_d   = (desc.encoding == ENC_SWAP16);
                enable_d = desc.enable && !region_bad_q;
                offset_d = '0;
                state_d  = (size_d == 24'd0) ? S_REGION : S_DATA;
            end
            S_DATA: if (take) begin
                checksum_d = checksum_q + 16'(in_data);
                offset_d   = offset_q + 24'd1;
                if (enable_q) begin
                    byte_wr = 1'b1;
                    issue   = (lane == LB'(BE_W - 1)) || last;
                end
                if (issue) begin
                    mem_addr_d = ADDR_W'(base_q) + ADDR_W'({offset_q[23:LB], {LB{1'b0}}});
                    mem_data_d = word_data;
                    mem_be_d   = word_be;
                    mem_req_d  = ~mem_req_q;
                    state_d    = S_WAIT;
                end else if (last) begin
                    state_d = S_REGION;
                end
            end
            S_WAIT: if (mem_ack == mem_req_q)
                state_d = (offset_q == size_q) ? S_REGION : S_DATA;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_CFG;
            cfg_cnt_q    <= '0;
            cfg_sh_q     <= '0;
            board_cfg_q  <= '0;
            region_idx_q <= RI_W'(N_REGIONS - 1);
            region_bad_q <= 1'b0;
            size_q       <= '0;
            offset_q     <= '0;
            base_q       <= '0;
            swap_q       <= 1'b0;
            enable_q     <= 1'b0;
            checksum_q   <= '0;
            error_q      <= 1'b0;
            done_q       <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_be_q     <= '0;
            mem_req_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_cnt_q    <= cfg_cnt_d;
            cfg_sh_q     <= cfg_sh_d;
            board_cfg_q  <= board_cfg_d;
            region_idx_q <= region_idx_d;
            region_bad_q <= region_bad_d;
            size_q       <= size_d;
            offset_q     <= offset_d;
            base_q       <= base_d;
            swap_q       <= swap_d;
            enable_q     <= enable_d;
            checksum_q   <= checksum_d;
            error_q      <= error_d;
            done_q       <= done_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_be_q     <= mem_be_d;
            mem_req_q    <= mem_req_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign mem_be    = mem_be_q;
    assign mem_req   = mem_req_q;
    assign board_cfg = board_cfg_q;
    assign done      = done_q;
    assign error     = error_q;
    assign checksum  = checksum_q;

endmodule
